// File: rtl/eth_fcs_check.sv
// Ethernet FCS checker: strips the 4-byte FCS from an AXI-Stream byte frame,
// flags CRC/length errors on the last beat and keeps saturating frame statistics.
module eth_fcs_check #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic        clk,
  input  logic        aresetn,
  output logic        axis_i_tready,
  input  logic        axis_i_tvalid,
  input  logic        axis_i_tlast,
  input  logic [7:0]  axis_i_tdata,
  input  logic        axis_o_tready,
  output logic        axis_o_tvalid,
  output logic        axis_o_tlast,
  output logic [7:0]  axis_o_tdata,
  output logic        axis_o_tuser,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad_fcs,
  output logic [15:0] stat_bad_len,
  output logic [15:0] stat_dropped
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME_BYTES);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic [3:0][7:0] dly_q, dly_d;
  logic [2:0]      fill_q, fill_d;
  logic [31:0]     crc_q, crc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            o_valid_q, o_valid_d, o_last_q, o_last_d, o_user_q, o_user_d;
  logic [7:0]      o_data_q, o_data_d;
  logic [15:0]     good_q, good_d, bad_fcs_q, bad_fcs_d, bad_len_q, bad_len_d, drop_q, drop_d;

  logic        in_hs, out_hs, buf_full, crc_bad, len_bad;
  logic [31:0] crc_next;
  logic [15:0] cnt_next;

  assign buf_full      = (fill_q == 3'd4);
  // Output beats only leave via the register, so input stalls only when it is full and blocked.
  assign axis_i_tready = aresetn & (~buf_full | ~o_valid_q | axis_o_tready);
  assign in_hs         = axis_i_tvalid & axis_i_tready;
  assign out_hs        = o_valid_q & axis_o_tready;
  assign crc_next      = crc32_byte(crc_q, axis_i_tdata);
  assign cnt_next      = sat_inc(cnt_q);
  assign crc_bad       = (crc_next != CRC_RESIDUE);
  assign len_bad       = (cnt_next < MIN_LEN) || (cnt_next > MAX_LEN);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    dly_d     = dly_q;
    fill_d    = fill_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q & ~out_hs;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    o_user_d  = o_user_q;
    good_d    = good_q;
    bad_fcs_d = bad_fcs_q;
    bad_len_d = bad_len_q;
    drop_d    = drop_q;

    if (in_hs) begin
      crc_d = crc_next;
      cnt_d = cnt_next;
      if (buf_full) begin
        o_valid_d = 1'b1;
        o_data_d  = dly_q[0];
        o_last_d  = axis_i_tlast;
        o_user_d  = axis_i_tlast & (crc_bad | len_bad);
        dly_d     = {axis_i_tdata, dly_q[3:1]};
      end else begin
        dly_d[fill_q[1:0]] = axis_i_tdata;
        fill_d             = fill_q + 3'd1;
      end

      if (axis_i_tlast) begin
        crc_d  = CRC_INIT;
        cnt_d  = '0;
        fill_d = '0;
        if (!buf_full)    drop_d    = sat_inc(drop_q);
        else if (crc_bad) bad_fcs_d = sat_inc(bad_fcs_q);
        else if (len_bad) bad_len_d = sat_inc(bad_len_q);
        else              good_d    = sat_inc(good_q);
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the 4-byte delay buffer is reset too; it is tiny and keeps tdata deterministic.
      dly_q     <= '0;
      fill_q    <= '0;
      crc_q     <= CRC_INIT;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_user_q  <= 1'b0;
      good_q    <= '0;
      bad_fcs_q <= '0;
      bad_len_q <= '0;
      drop_q    <= '0;
    end else begin
      dly_q     <= dly_d;
      fill_q    <= fill_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_user_q  <= o_user_d;
      good_q    <= good_d;
      bad_fcs_q <= bad_fcs_d;
      bad_len_q <= bad_len_d;
      drop_q    <= drop_d;
    end
  end

  assign axis_o_tvalid = o_valid_q;
  assign axis_o_tdata  = o_data_q;
  assign axis_o_tlast  = o_last_q;
  assign axis_o_tuser  = o_user_q;
  assign stat_good     = good_q;
  assign stat_bad_fcs  = bad_fcs_q;
  assign stat_bad_len  = bad_len_q;
  assign stat_dropped  = drop_q;

endmodule

// File: tb/tb_eth_fcs_check.sv
// Directed bench for eth_fcs_check: builds frames with a bench-side FCS and
// scores the stripped output stream, error flags and statistics.
module tb_eth_fcs_check;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        axis_i_tready, axis_i_tvalid, axis_i_tlast;
  logic [7:0]  axis_i_tdata;
  logic        axis_o_tready = 1'b1;
  logic        axis_o_tvalid, axis_o_tlast, axis_o_tuser;
  logic [7:0]  axis_o_tdata;
  logic [15:0] stat_good, stat_bad_fcs, stat_bad_len, stat_dropped;

  eth_fcs_check dut (
    .clk(clk), .aresetn(aresetn),
    .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tlast(axis_i_tlast), .axis_i_tdata(axis_i_tdata),
    .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid),
    .axis_o_tlast(axis_o_tlast), .axis_o_tdata(axis_o_tdata), .axis_o_tuser(axis_o_tuser),
    .stat_good(stat_good), .stat_bad_fcs(stat_bad_fcs),
    .stat_bad_len(stat_bad_len), .stat_dropped(stat_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         cyc;
  } beat_t;

  beat_t      out_q[$];
  logic [7:0] frm[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int         cyc = 0;
  int         first_in_cyc = 0;
  int         n_vec = 0;
  int         n_miscmp = 0;
  bit         stall_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    axis_o_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk)
    if (aresetn && axis_o_tvalid && axis_o_tready)
      out_q.push_back('{axis_o_tdata, axis_o_tlast, axis_o_tuser, cyc});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // Payload pattern plus a correct FCS, transmitted least significant byte first.
  task automatic make_frame(input int n_pay, input int seed);
    logic [31:0] crc, fcs;
    logic [7:0]  b;
    frm = {};
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < n_pay; i++) begin
      b = 8'(i * 7 + seed * 13 + 3);
      frm.push_back(b);
      crc = crc_upd(crc, b);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
  endtask

  // Drives frm[0..n_send-1]; tlast only when the whole frame is sent. Entered/left at posedge+1.
  task automatic send_frame(input int gap_pct, input int n_send);
    bit hs;
    int t;
    for (int i = 0; i < n_send; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        axis_i_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      axis_i_tvalid = 1'b1;
      axis_i_tdata  = frm[i];
      axis_i_tlast  = (i == frm.size() - 1);
      t = 0;
      do begin
        @(negedge clk);
        hs = axis_i_tready;
        if (hs && i == 0) first_in_cyc = cyc;
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 2000);
      if (!hs) begin
        check("in_hs_timeout", 32'(t), 0);
        $fatal(1, "input handshake never completed");
      end
    end
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int t = 0;
    while (out_q.size() < n && t < budget) begin
      @(posedge clk); t++;
    end
    if (out_q.size() < n) check({tag, "_timeout"}, 32'(out_q.size()), 32'(n));
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Scores out_q against frm minus its FCS; every beat must carry tuser=0 except the last.
  task automatic check_frame(input string tag, input logic exp_user);
    int n_pay, bad_data, bad_last, bad_user;
    beat_t b;
    n_pay = frm.size() - 4;
    wait_beats(tag, n_pay, 4000);
    check({tag, "_beats"}, 32'(out_q.size()), 32'(n_pay));
    bad_data = 0; bad_last = 0; bad_user = 0;
    for (int i = 0; i < n_pay && out_q.size() > 0; i++) begin
      b = out_q.pop_front();
      if (b.data !== frm[i]) bad_data++;
      if (b.last !== (i == n_pay - 1)) bad_last++;
      if (b.user !== ((i == n_pay - 1) ? exp_user : 1'b0)) bad_user++;
    end
    check({tag, "_data_errs"}, 32'(bad_data), 0);
    check({tag, "_last_errs"}, 32'(bad_last), 0);
    check({tag, "_user_errs"}, 32'(bad_user), 0);
    out_q = {};
  endtask

  task automatic check_stats(input string tag, input int g, input int f, input int l, input int d);
    check({tag, "_good"},    32'(stat_good),    32'(g));
    check({tag, "_bad_fcs"}, 32'(stat_bad_fcs), 32'(f));
    check({tag, "_bad_len"}, 32'(stat_bad_len), 32'(l));
    check({tag, "_dropped"}, 32'(stat_dropped), 32'(d));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_i_tready"}, 32'(axis_i_tready), 0);
    check({tag, "_o_tvalid"}, 32'(axis_o_tvalid), 0);
    check({tag, "_o_tdata"},  32'(axis_o_tdata),  0);
    check({tag, "_o_tlast"},  32'(axis_o_tlast),  0);
    check({tag, "_o_tuser"},  32'(axis_o_tuser),  0);
    check_stats(tag, 0, 0, 0, 0);
  endtask

  initial begin
    int total, bad_data, bad_last, bad_user, lat;
    beat_t b;

    aresetn = 1'b0;
    axis_i_tvalid = 1'b0; axis_i_tlast = 1'b0; axis_i_tdata = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    aresetn = 1'b1;
    @(posedge clk); #1;
    check("idle_i_tready", 32'(axis_i_tready), 1);

    // Good 64-byte frame, unstalled; first output one cycle after byte 5 is taken.
    make_frame(60, 1);
    send_frame(0, frm.size());
    wait_beats("good_lat", 1, 100);
    lat = (out_q.size() > 0) ? out_q[0].cyc - first_in_cyc : -1;
    check("good_latency", 32'(lat), 5);
    check_frame("good", 1'b0);
    check_stats("good", 1, 0, 0, 0);

    // Payload byte 10 bit 0 flipped after FCS computed.
    make_frame(60, 2);
    frm[10] = frm[10] ^ 8'h01;
    send_frame(0, frm.size());
    check_frame("badfcs", 1'b1);
    check_stats("badfcs", 1, 1, 0, 0);

    // 3-byte runt immediately followed by a good frame.
    frm = {8'h11, 8'h22, 8'h33};
    frm[2] = 8'h33;
    axis_i_tvalid = 1'b0;
    send_frame(0, 3);
    make_frame(60, 3);
    send_frame(0, frm.size());
    check_frame("runt_next", 1'b0);
    check_stats("runt", 2, 1, 0, 1);

    // Length errors with correct FCS: short and oversize.
    make_frame(36, 4);
    send_frame(0, frm.size());
    check_frame("short", 1'b1);
    check_stats("short", 2, 1, 1, 1);
    make_frame(1596, 5);
    send_frame(0, frm.size());
    check_frame("long", 1'b1);
    check_stats("long", 2, 1, 2, 1);

    // 100 frames with random output stalls and input gaps.
    stall_en = 1'b1;
    exp_data = {}; exp_last = {};
    for (int f = 0; f < 100; f++) begin
      make_frame(60 + (f % 16), 10 + f);
      for (int i = 0; i < frm.size() - 4; i++) begin
        exp_data.push_back(frm[i]);
        exp_last.push_back(i == frm.size() - 5);
      end
      send_frame(30, frm.size());
    end
    total = exp_data.size();
    wait_beats("stress", total, 20000);
    stall_en = 1'b0;
    check("stress_beats", 32'(out_q.size()), 32'(total));
    bad_data = 0; bad_last = 0; bad_user = 0;
    for (int i = 0; i < total && out_q.size() > 0; i++) begin
      b = out_q.pop_front();
      if (b.data !== exp_data[i]) bad_data++;
      if (b.last !== exp_last[i]) bad_last++;
      if (b.user !== 1'b0) bad_user++;
    end
    check("stress_data_errs", 32'(bad_data), 0);
    check("stress_last_errs", 32'(bad_last), 0);
    check("stress_user_errs", 32'(bad_user), 0);
    check_stats("stress", 102, 1, 2, 1);
    out_q = {};

    // Reset at input byte 30: partial frame discarded, statistics cleared.
    repeat (2) @(posedge clk); #1;
    make_frame(60, 7);
    send_frame(0, 30);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    bad_last = 0;
    foreach (out_q[i]) if (out_q[i].last) bad_last++;
    check("midrst_no_last", 32'(bad_last), 0);
    out_q = {};
    repeat (3) @(negedge clk);
    check("midrst_hold_o_tvalid", 32'(axis_o_tvalid), 0);
    aresetn = 1'b1;
    @(posedge clk); #1;
    make_frame(60, 8);
    send_frame(0, frm.size());
    check_frame("after_rst", 1'b0);
    check_stats("after_rst", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/eth_fcs_check.md
ETH_FCS_CHECK -- requirements
Module: eth_fcs_check

Interface
REQ-001 SHALL have parameter MIN_FRAME_BYTES, default 64, minimum legal frame length in bytes including FCS.
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 1522, maximum legal frame length in bytes including FCS.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports axis_i_tready output 1, axis_i_tvalid input 1, axis_i_tlast input 1, axis_i_tdata input 8: preamble-stripped frame bytes from the GMII receive MAC, FCS included.
REQ-006 SHALL have ports axis_o_tready input 1, axis_o_tvalid output 1, axis_o_tlast output 1, axis_o_tdata output 8, axis_o_tuser output 1: frame without FCS; tuser is the frame-error flag.
REQ-007 SHALL have outputs stat_good, stat_bad_fcs, stat_bad_len, stat_dropped, each 16 bits: saturating frame counters.

Function
REQ-008 SHALL hold a 4-byte delay buffer with fill count 0..4, a reflected CRC-32 register (poly 0x04C11DB7, init 0xFFFFFFFF, no final XOR) and a 16-bit saturating byte counter.
REQ-009 SHALL assert axis_i_tready when not in reset and (fill<4 or output register empty or axis_o_tready=1).
REQ-010 SHALL, on each input handshake, update CRC with the byte, increment the byte counter, and push the byte into the delay buffer.
REQ-011 SHALL, on an input handshake with fill=4, load the oldest buffered byte into the output register (tvalid=1).
REQ-012 SHALL keep the output register stable while axis_o_tvalid=1 and axis_o_tready=0.
REQ-013 SHALL clear axis_o_tvalid after an output handshake unless a new byte is loaded that same cycle.
REQ-014 SHALL, on the input handshake carrying tlast, set output tlast=1 on the byte loaded that cycle, i.e. the last non-FCS byte; the 4 buffered FCS bytes are discarded.
REQ-015 SHALL set output tuser=1 on that last beat if the CRC register after the final byte is not 0xDEBB20E3, or the byte count is <MIN_FRAME_BYTES or >MAX_FRAME_BYTES; tuser=0 on all non-last beats.
REQ-016 SHALL, after a tlast input handshake, reset CRC to 0xFFFFFFFF, byte count to 0 and fill to 0 in the same cycle, so the next frame may start on the following cycle.
REQ-017 SHALL, when tlast arrives with fill<4 (frame of 1..4 bytes), emit no output beat, increment stat_dropped, and reset frame state as in REQ-016.
REQ-018 SHALL increment exactly one counter per frame: stat_good (tuser=0), stat_bad_fcs (CRC bad), stat_bad_len (CRC good, length bad), stat_dropped (REQ-017); each counter holds at 0xFFFF.
REQ-019 SHALL saturate the byte counter at 0xFFFF so oversize frames still report length error.
REQ-020 SHALL add latency of exactly one cycle from the input handshake of byte N+4 to output valid of byte N when the output is unstalled.
REQ-021 SHALL sustain one byte per cycle throughput with axis_o_tready held at 1.

Reset
REQ-022 SHALL, while aresetn=0, drive axis_i_tready=0, axis_o_tvalid=0, axis_o_tlast=0, axis_o_tuser=0, axis_o_tdata=0, all stat counters 0, fill 0, byte count 0, CRC 0xFFFFFFFF.
REQ-023 SHALL, on reset asserted mid-frame, discard the partial frame with no output beat and no counter update; the first byte after release starts a new frame.

Verification
REQ-024 SHALL pass: 64-byte frame (60 payload + correct FCS), tready=1 -> 60 output bytes matching payload, tlast and tuser=0 on byte 60, stat_good=1.
REQ-025 SHALL pass: same frame with payload byte 10 bit 0 flipped -> 60 bytes, tuser=1 on last, stat_bad_fcs=1, stat_good=0.
REQ-026 SHALL pass: 3-byte frame then valid 64-byte frame back-to-back -> no output for first, stat_dropped=1, second frame 60 bytes tuser=0.
REQ-027 SHALL pass: 40-byte frame with correct FCS -> 36 bytes, tuser=1, stat_bad_len=1; 1600-byte correct frame -> 1596 bytes, tuser=1, stat_bad_len=2.
REQ-028 SHALL pass: random axis_o_tready (50%) and gapped axis_i_tvalid over 100 frames -> output byte stream identical to stall-free run, no loss or duplication.
REQ-029 SHALL pass: aresetn pulsed low at input byte 30 of a frame -> all outputs 0 during reset, no output for that frame, next valid frame gives stat_good=1.
